// File: rtl/instr_done_arbiter_pkg.sv
// Shared issue-stage constants for the instruction-completion arbiter.
package instr_done_arbiter_pkg;

   localparam int unsigned ISSUE_INSTR_INFO_LENGTH = 32;

   localparam int unsigned WFID_W        = 6;
   localparam int unsigned INFO_W        = ISSUE_INSTR_INFO_LENGTH;
   localparam int unsigned NUM_SRC       = 4;
   localparam int unsigned SRC_W         = 2;
   localparam int unsigned DEFAULT_DEPTH = 4;

   localparam logic [SRC_W-1:0] SRC_VALU = 2'd0;
   localparam logic [SRC_W-1:0] SRC_VLSU = 2'd1;
   localparam logic [SRC_W-1:0] SRC_SALU = 2'd2;
   localparam logic [SRC_W-1:0] SRC_SLSU = 2'd3;

endpackage

// File: rtl/instr_done_arbiter_done_fifo.sv
// Per-source completion FIFO of wavefront IDs with occupancy count and
// a head output that reads as zero while empty.
module done_fifo
   import instr_done_arbiter_pkg::*;
#(
   parameter int unsigned WFID_W = instr_done_arbiter_pkg::WFID_W,
   parameter int unsigned DEPTH  = DEFAULT_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WFID_W-1:0]        push_wfid,
   input  logic                     pop,
   output logic [WFID_W-1:0]        head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WFID_W-1:0] mem_q [DEPTH];
   logic [WFID_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              do_push, do_pop;

   // Guarded push/pop; pointers wrap naturally because DEPTH is a power of 2.
   always_comb begin
      do_push  = push && (count_q < CNT_W'(DEPTH));
      do_pop   = pop && (count_q != '0);
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_wfid;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head  = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/instr_done_arbiter.sv
// Buffers completion events from four writeback sources, looks up their
// instruction info and emits one round-robin ordered retire stream.
module instr_done_arbiter
   import instr_done_arbiter_pkg::*;
#(
   parameter int unsigned WFID_W = instr_done_arbiter_pkg::WFID_W,
   parameter int unsigned INFO_W = instr_done_arbiter_pkg::INFO_W,
   parameter int unsigned DEPTH  = DEFAULT_DEPTH
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_SRC-1:0]          done_valid,
   input  logic [NUM_SRC*WFID_W-1:0]   done_wfid,
   output logic [NUM_SRC-1:0]          done_ready,
   output logic [NUM_SRC*WFID_W-1:0]   tbl_rd_wfid,
   input  logic [NUM_SRC*INFO_W-1:0]   tbl_rd_data,
   output logic                        retire_valid,
   input  logic                        retire_ready,
   output logic [WFID_W-1:0]           retire_wfid,
   output logic [SRC_W-1:0]            retire_src,
   output logic [INFO_W-1:0]           retire_info,
   output logic                        busy
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [NUM_SRC-1:0] push, pop, nonempty;
   logic [CNT_W-1:0]   count [NUM_SRC];
   logic [WFID_W-1:0]  head  [NUM_SRC];

   logic               retire_valid_q, retire_valid_d;
   logic [WFID_W-1:0]  retire_wfid_q, retire_wfid_d;
   logic [SRC_W-1:0]   retire_src_q, retire_src_d;
   logic [INFO_W-1:0]  retire_info_q, retire_info_d;
   logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;

   logic               load_en, grant;
   logic [SRC_W-1:0]   grant_idx, cand;

   for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      done_fifo #(
         .WFID_W (WFID_W),
         .DEPTH  (DEPTH)
      ) u_fifo (
         .clk       (clk),
         .rst       (rst),
         .push      (push[s]),
         .push_wfid (done_wfid[s*WFID_W +: WFID_W]),
         .pop       (pop[s]),
         .head      (head[s]),
         .count     (count[s])
      );

      // Ready comes from the registered count only, so a full FIFO stays
      // closed even in a cycle where it is being popped.
      assign done_ready[s] = (count[s] < CNT_W'(DEPTH));
      assign nonempty[s]   = (count[s] != '0);
      assign push[s]       = done_valid[s] & done_ready[s];
      assign tbl_rd_wfid[s*WFID_W +: WFID_W] = head[s];
   end

   // Round-robin pick starting at rr_ptr, gated by output-register space.
   always_comb begin
      load_en   = !retire_valid_q || retire_ready;
      grant     = 1'b0;
      grant_idx = '0;
      cand      = '0;
      pop       = '0;
      for (int i = 0; i < int'(NUM_SRC); i++) begin
         cand = rr_ptr_q + SRC_W'(i);
         if (!grant && load_en && nonempty[cand]) begin
            grant     = 1'b1;
            grant_idx = cand;
         end
      end
      if (grant) begin
         pop[grant_idx] = 1'b1;
      end
   end

   // Output register: load on grant, drain on accept, otherwise hold.
   always_comb begin
      retire_valid_d = retire_valid_q;
      retire_wfid_d  = retire_wfid_q;
      retire_src_d   = retire_src_q;
      retire_info_d  = retire_info_q;
      rr_ptr_d       = rr_ptr_q;
      if (grant) begin
         retire_valid_d = 1'b1;
         retire_wfid_d  = head[grant_idx];
         retire_src_d   = grant_idx;
         rr_ptr_d       = grant_idx + SRC_W'(1);
         for (int s = 0; s < int'(NUM_SRC); s++) begin
            if (grant_idx == SRC_W'(s)) begin
               retire_info_d = tbl_rd_data[s*INFO_W +: INFO_W];
            end
         end
      end else if (retire_ready) begin
         retire_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         retire_valid_q <= 1'b0;
         retire_wfid_q  <= '0;
         retire_src_q   <= '0;
         retire_info_q  <= '0;
         rr_ptr_q       <= '0;
      end else begin
         retire_valid_q <= retire_valid_d;
         retire_wfid_q  <= retire_wfid_d;
         retire_src_q   <= retire_src_d;
         retire_info_q  <= retire_info_d;
         rr_ptr_q       <= rr_ptr_d;
      end
   end

   assign retire_valid = retire_valid_q;
   assign retire_wfid  = retire_wfid_q;
   assign retire_src   = retire_src_q;
   assign retire_info  = retire_info_q;
   assign busy         = (|nonempty) | retire_valid_q;

endmodule

// File: tb/tb_instr_done_arbiter.sv
// Scoreboard bench for instr_done_arbiter: a queue-level reference model
// predicts retire records and a monitor compares DUT outputs every cycle.
module tb_instr_done_arbiter;
   import instr_done_arbiter_pkg::*;

   localparam int unsigned W  = instr_done_arbiter_pkg::WFID_W;
   localparam int unsigned IW = instr_done_arbiter_pkg::INFO_W;
   localparam int unsigned D  = DEFAULT_DEPTH;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [3:0]        done_valid = '0;
   logic [4*W-1:0]    done_wfid = '0;
   logic [3:0]        done_ready;
   logic [4*W-1:0]    tbl_rd_wfid;
   logic [4*IW-1:0]   tbl_rd_data;
   logic              retire_valid;
   logic              retire_ready = 1'b0;
   logic [W-1:0]      retire_wfid;
   logic [1:0]        retire_src;
   logic [IW-1:0]     retire_info;
   logic              busy;

   logic [IW-1:0]     tbl_mem [4][64];

   typedef struct packed {
      logic [W-1:0]  wfid;
      logic [1:0]    src;
      logic [IW-1:0] info;
   } rec_t;

   logic [W-1:0] mq [4][$];
   rec_t         exp_q [$];
   int           mrr = 0;
   bit           fields_zero = 1'b1;

   int checks = 0;
   int failures = 0;

   instr_done_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .done_valid   (done_valid),
      .done_wfid    (done_wfid),
      .done_ready   (done_ready),
      .tbl_rd_wfid  (tbl_rd_wfid),
      .tbl_rd_data  (tbl_rd_data),
      .retire_valid (retire_valid),
      .retire_ready (retire_ready),
      .retire_wfid  (retire_wfid),
      .retire_src   (retire_src),
      .retire_info  (retire_info),
      .busy         (busy)
   );

   for (genvar s = 0; s < 4; s++) begin : g_tbl
      assign tbl_rd_data[s*IW +: IW] = tbl_mem[s][tbl_rd_wfid[s*W +: W]];
   end

   initial begin
      forever begin
         #5 clk = ~clk;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: per-source queues plus a one-deep retire slot.
   initial begin
      bit   acc [4];
      bit   load;
      int   g;
      rec_t r;
      forever begin
         @(posedge clk);
         if (!rst) begin
            for (int s = 0; s < 4; s++) mq[s].delete();
            exp_q.delete();
            mrr = 0;
            fields_zero = 1'b1;
         end else begin
            for (int s = 0; s < 4; s++) acc[s] = done_valid[s] && (mq[s].size() < int'(D));
            load = (exp_q.size() == 0) || retire_ready;
            if (exp_q.size() != 0 && retire_ready) void'(exp_q.pop_front());
            if (load) begin
               for (int i = 0; i < 4; i++) begin
                  g = (mrr + i) % 4;
                  if (mq[g].size() > 0) begin
                     r.wfid = mq[g].pop_front();
                     r.src  = 2'(g);
                     r.info = tbl_mem[g][r.wfid];
                     exp_q.push_back(r);
                     mrr = (g + 1) % 4;
                     fields_zero = 1'b0;
                     break;
                  end
               end
            end
            for (int s = 0; s < 4; s++) begin
               if (acc[s]) mq[s].push_back(done_wfid[s*W +: W]);
            end
         end
      end
   end

   // Monitor: compares presented outputs with the model between edges.
   initial begin
      bit any;
      @(posedge clk);
      forever begin
         @(negedge clk);
         any = (exp_q.size() != 0);
         chk("retire_valid", 64'(retire_valid), 64'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            chk("retire_wfid", 64'(retire_wfid), 64'(exp_q[0].wfid));
            chk("retire_src",  64'(retire_src),  64'(exp_q[0].src));
            chk("retire_info", 64'(retire_info), 64'(exp_q[0].info));
         end else if (fields_zero) begin
            chk("retire_wfid_rst", 64'(retire_wfid), 64'(0));
            chk("retire_src_rst",  64'(retire_src),  64'(0));
            chk("retire_info_rst", 64'(retire_info), 64'(0));
         end
         for (int s = 0; s < 4; s++) begin
            chk("done_ready", 64'(done_ready[s]), 64'(mq[s].size() < int'(D)));
            chk("tbl_rd_wfid", 64'(tbl_rd_wfid[s*W +: W]),
                64'((mq[s].size() != 0) ? mq[s][0] : W'(0)));
            if (mq[s].size() != 0) any = 1'b1;
         end
         chk("busy", 64'(busy), 64'(any));
      end
   end

   task automatic idle(input int n);
      done_valid = '0;
      repeat (n) @(negedge clk);
   endtask

   // Hold one event on source s until the DUT can take it (bounded).
   task automatic send(input int s, input int w);
      bit acc;
      int n;
      acc = 1'b0;
      n   = 0;
      done_valid = '0;
      done_valid[s] = 1'b1;
      done_wfid[s*W +: W] = W'(w);
      while (!acc && n < 16) begin
         acc = done_ready[s];
         @(negedge clk);
         n++;
      end
      done_valid = '0;
      chk("send_accept", 64'(acc), 64'(1));
   endtask

   initial begin
      for (int s = 0; s < 4; s++)
         for (int w = 0; w < 64; w++) tbl_mem[s][w] = IW'($urandom);
      tbl_mem[0][17] = IW'('hA5);

      rst = 1'b0;
      done_valid = 4'hf;
      done_wfid = 4*W'($urandom);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      retire_ready = 1'b1;
      idle(3);

      send(int'(SRC_VALU), 17);
      idle(4);

      done_valid = 4'hf;
      for (int s = 0; s < 4; s++) done_wfid[s*W +: W] = W'(s + 1);
      @(negedge clk);
      idle(6);
      done_valid = 4'b1010;
      done_wfid[1*W +: W] = W'(5);
      done_wfid[3*W +: W] = W'(6);
      @(negedge clk);
      idle(4);

      retire_ready = 1'b0;
      for (int k = 0; k < 5; k++) send(int'(SRC_SALU), 20 + k);
      done_valid = 4'b0100;
      done_wfid[2*W +: W] = W'(26);
      repeat (3) @(negedge clk);
      retire_ready = 1'b1;
      send(int'(SRC_SALU), 26);
      idle(8);

      retire_ready = 1'b0;
      for (int k = 0; k < 4; k++) send(int'(SRC_VALU), 30 + k);
      retire_ready = 1'b1;
      for (int k = 4; k < 10; k++) send(int'(SRC_VALU), 30 + k);
      idle(8);

      retire_ready = 1'b0;
      for (int k = 0; k < 4; k++) send(int'(SRC_VLSU), 8 + k);
      rst = 1'b0;
      retire_ready = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      idle(6);

      send(int'(SRC_SLSU), 39);
      idle(4);

      for (int c = 0; c < 2000; c++) begin
         done_valid = 4'($urandom);
         for (int s = 0; s < 4; s++) done_wfid[s*W +: W] = W'($urandom_range(0, 39));
         retire_ready = ($urandom_range(0, 9) < 7);
         rst = ($urandom_range(0, 599) != 0);
         @(negedge clk);
      end

      rst = 1'b1;
      retire_ready = 1'b1;
      idle(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
